// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive path.
//   state_t      : receive sequencer states, 2-bit encoding
//   *_DFLT       : default frame geometry (data bits, oversampling, stop ticks)
//   max2         : elaboration-time helper for counter sizing
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned DBIT_DFLT    = 8;
  localparam int unsigned OS_DFLT      = 16;
  localparam int unsigned SB_TICK_DFLT = 16;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side result bus between the UART sequencer and its consumer
// (rx FIFO / host interface).
//   dout         : last received data word, LSB = first bit on the line
//   rx_done_tick : one-clk pulse, dout valid
//   frame_err    : one-clk pulse with rx_done_tick when the stop bit was low
//   busy         : sequencer is inside a frame
// master = the receiver driving results, slave = the consumer.
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int unsigned DBIT = DBIT_DFLT
);

  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;

  modport master (output dout, rx_done_tick, frame_err, busy);
  modport slave  (input  dout, rx_done_tick, frame_err, busy);

endinterface

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   reset : asynchronous, active-low; both flops load RST_VAL
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clk of latency
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer clocked by an OS x baud tick. Detects the start
// edge, validates the start bit at mid-bit, samples DBIT data bits LSB-first
// at bit centres, then samples the stop bit and publishes the word.
//   clk    : system clock
//   reset  : asynchronous, active-low
//   rx     : asynchronous serial line, idle high
//   s_tick : one-clk pulse at OS x baud
//   rx_bus : result bus (dout, rx_done_tick, frame_err, busy), master side
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DFLT,
  parameter int unsigned OS      = OS_DFLT,
  parameter int unsigned SB_TICK = SB_TICK_DFLT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  input  logic           s_tick,
  uart_rx_ctrl_if.master rx_bus
);

  localparam int unsigned SW = $clog2(max2(OS, SB_TICK));
  localparam int unsigned NW = $clog2(DBIT) + 1;

  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rx_s;
  logic            rx_prev_q;
  state_t          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] shift_q;
  logic [DBIT-1:0] shift_d;
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            ferr_q;
  logic            busy_q;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  // LSB arrives first: each new sample enters at the MSB and walks right.
  assign shift_d = {rx_s, shift_q[DBIT-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_prev_q <= rx_s;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      unique case (state_q)
        // Edge-triggered start: a line that stays low after a frame (break)
        // cannot restart until it has risen again.
        IDLE: begin
          if (rx_prev_q && !rx_s) begin
            state_q <= START;
            s_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == S_HALF) begin
              if (!rx_s) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == S_BIT) begin
              shift_q <= shift_d;
              s_q     <= '0;
              n_q     <= n_q + 1'b1;
              if (n_q == N_LAST) begin
                state_q <= STOP;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == S_STOP) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              dout_q  <= shift_q;
              ferr_q  <= ~rx_s;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_bus.dout         = dout_q;
  assign rx_bus.rx_done_tick = done_q;
  assign rx_bus.frame_err    = ferr_q;
  assign rx_bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: one default instance (8N1, OS=16) and one with
// DBIT=7 / SB_TICK=32. Frames are driven tick-accurately on the line; each
// frame pushes its expected word, error flag and latency into a per-DUT
// scoreboard that a monitor pops on every rx_done_tick.
module tb_uart_rx_ctrl;

  localparam int CLK_P = 10;

  typedef struct packed {
    logic [8:0]  data;
    logic        ferr;
    logic [31:0] lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic s_tick;
  logic rx_a;
  logic rx_b;

  int checks = 0;
  int errors = 0;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  int unsigned done_cnt[2];
  int unsigned start_cnt[2];
  int unsigned lat[2];
  logic        busy_prev[2];
  time         t_fall[2];
  time         start_dly[2];

  uart_rx_ctrl_if #(.DBIT(8)) bus_a ();
  uart_rx_ctrl_if #(.DBIT(7)) bus_b ();

  uart_rx_ctrl #(.DBIT(8), .OS(16), .SB_TICK(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .rx    (rx_a),
    .s_tick(s_tick),
    .rx_bus(bus_a.master)
  );

  uart_rx_ctrl #(.DBIT(7), .OS(16), .SB_TICK(32)) dut_b (
    .clk   (clk),
    .reset (reset),
    .rx    (rx_b),
    .s_tick(s_tick),
    .rx_bus(bus_b.master)
  );

  always #(CLK_P / 2) clk = ~clk;

  // s_tick: one clk high out of every four
  initial begin
    int unsigned c;
    c = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      s_tick = (c % 4 == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: latency in ticks since start detection, scoreboard on strobes
  initial begin
    logic       tk;
    logic [8:0] dv[2];
    logic       dn[2];
    logic       fe[2];
    logic       bz[2];
    int         sz;
    exp_t       e;
    for (int i = 0; i < 2; i++) begin
      done_cnt[i]  = 0;
      start_cnt[i] = 0;
      lat[i]       = 0;
      busy_prev[i] = 1'b0;
      t_fall[i]    = 0;
      start_dly[i] = 0;
    end
    forever begin
      @(posedge clk);
      tk = s_tick;
      #1;
      dv[0] = 9'(bus_a.dout);
      dv[1] = 9'(bus_b.dout);
      dn[0] = bus_a.rx_done_tick;
      dn[1] = bus_b.rx_done_tick;
      fe[0] = bus_a.frame_err;
      fe[1] = bus_b.frame_err;
      bz[0] = bus_a.busy;
      bz[1] = bus_b.busy;
      for (int i = 0; i < 2; i++) begin
        if (busy_prev[i] === 1'b1 && tk) lat[i]++;
        if (bz[i] === 1'b1 && busy_prev[i] !== 1'b1) begin
          lat[i] = 0;
          start_cnt[i]++;
          start_dly[i] = $time - t_fall[i];
        end
        if (dn[i] === 1'b1) begin
          done_cnt[i]++;
          sz = (i == 0) ? sb_a.size() : sb_b.size();
          checks++;
          assert (sz != 0) else begin
            errors++;
            $error("FAIL unexpected_strobe_%0d observed=%0d pending expected=nonzero", i, sz);
          end
          if (sz != 0) begin
            if (i == 0) e = sb_a.pop_front();
            else        e = sb_b.pop_front();
            chk($sformatf("dout_%0d", i), 32'(dv[i]), 32'(e.data));
            chk($sformatf("frame_err_%0d", i), 32'(fe[i]), 32'(e.ferr));
            chk($sformatf("latency_ticks_%0d", i), lat[i], e.lat);
            chk($sformatf("busy_at_done_%0d", i), 32'(bz[i]), 32'd0);
          end
        end
        busy_prev[i] = bz[i];
      end
    end
  end

  task automatic set_rx(input int sel, input logic v);
    @(negedge clk);
    if (sel == 0) begin
      if (rx_a && !v) t_fall[0] = $time;
      rx_a = v;
    end else begin
      if (rx_b && !v) t_fall[1] = $time;
      rx_b = v;
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!s_tick);
    end
  endtask

  task automatic hold(input int sel, input logic v, input int n);
    set_rx(sel, v);
    wait_ticks(n);
  endtask

  task automatic send(input int sel, input logic [8:0] d, input int nb,
                      input logic stop_v, input int sbt);
    exp_t e;
    e.data = d;
    e.ferr = ~stop_v;
    e.lat  = 32'(16 / 2 + nb * 16 + sbt);
    if (sel == 0) sb_a.push_back(e);
    else          sb_b.push_back(e);
    hold(sel, 1'b0, 16);
    for (int i = 0; i < nb; i++) hold(sel, d[i], 16);
    hold(sel, stop_v, sbt);
  endtask

  initial begin
    #(50000 * CLK_P);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n0;
    int unsigned s0;
    reset = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_dout_a", 32'(bus_a.dout), 32'h0);
    chk("rst_done_a", 32'(bus_a.rx_done_tick), 32'h0);
    chk("rst_ferr_a", 32'(bus_a.frame_err), 32'h0);
    chk("rst_busy_a", 32'(bus_a.busy), 32'h0);
    chk("rst_dout_b", 32'(bus_b.dout), 32'h0);
    chk("rst_busy_b", 32'(bus_b.busy), 32'h0);
    reset = 1'b1;
    hold(0, 1'b1, 8);

    // 0x55, one stop bit
    send(0, 9'h055, 8, 1'b1, 16);
    hold(0, 1'b1, 16);
    chk("cnt_after_55", done_cnt[0], 32'd1);

    // break: line low long enough for a whole frame and more
    n0 = done_cnt[0];
    sb_a.push_back('{data: 9'h000, ferr: 1'b1, lat: 32'd152});
    hold(0, 1'b0, 400);
    chk("break_one_strobe", done_cnt[0], n0 + 1);
    chk("break_no_retrigger_busy", 32'(bus_a.busy), 32'h0);
    hold(0, 1'b1, 32);
    chk("break_cnt_after_rise", done_cnt[0], n0 + 1);

    // back-to-back 0xA3, 0x0F
    n0 = done_cnt[0];
    send(0, 9'h0A3, 8, 1'b1, 16);
    send(0, 9'h00F, 8, 1'b1, 16);
    chk("b2b_start_within_3clk", {31'b0, start_dly[0] <= time'(3 * CLK_P + 1)}, 32'd1);
    hold(0, 1'b1, 16);
    chk("b2b_two_strobes", done_cnt[0], n0 + 2);
    chk("b2b_dout_last", 32'(bus_a.dout), 32'h0F);

    // start glitch: low for 5 ticks only
    n0 = done_cnt[0];
    s0 = start_cnt[0];
    hold(0, 1'b0, 5);
    hold(0, 1'b1, 24);
    chk("glitch_seen_start", start_cnt[0], s0 + 1);
    chk("glitch_busy", 32'(bus_a.busy), 32'h0);
    chk("glitch_dout_kept", 32'(bus_a.dout), 32'h0F);
    chk("glitch_no_strobe", done_cnt[0], n0);

    // reset during data bit 4 of 0xFF
    n0 = done_cnt[0];
    hold(0, 1'b0, 16);
    hold(0, 1'b1, 70);
    chk("pre_reset_busy", 32'(bus_a.busy), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_dout", 32'(bus_a.dout), 32'h0);
    chk("midrst_done", 32'(bus_a.rx_done_tick), 32'h0);
    chk("midrst_ferr", 32'(bus_a.frame_err), 32'h0);
    chk("midrst_busy", 32'(bus_a.busy), 32'h0);
    reset = 1'b1;
    hold(0, 1'b1, 40);
    chk("midrst_no_strobe", done_cnt[0], n0);

    send(0, 9'h081, 8, 1'b1, 16);
    hold(0, 1'b1, 16);
    chk("post_rst_strobe", done_cnt[0], n0 + 1);
    chk("post_rst_dout", 32'(bus_a.dout), 32'h81);

    // DBIT=7, 2 stop bits: good stop, then stop held low
    hold(1, 1'b1, 8);
    send(1, 9'h05A, 7, 1'b1, 32);
    hold(1, 1'b1, 16);
    chk("b_dout_5a", 32'(bus_b.dout), 32'h5A);
    send(1, 9'h02B, 7, 1'b0, 32);
    hold(1, 1'b1, 32);
    chk("b_strobes", done_cnt[1], 32'd2);

    chk("sb_a_drained", sb_a.size(), 32'd0);
    chk("sb_b_drained", sb_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
